test_seq_ctrl: RTL and testbench
================================

TEST_SEQ_CTRL -- requirements
Module: test_seq_ctrl

Interface
REQ-001 SHALL have parameter GOLDEN_SIG, default 8'h00: expected fault-free signature.
REQ-002 SHALL have parameter NUM_PAT, default 64: patterns applied per run, legal range 2..64.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: run request, level-sampled.
REQ-006 SHALL have port cut_z, input, 1: circuit-under-test response Z.
REQ-007 SHALL have port pat, output, 6: registered pattern driven to CUT inputs {A,B,C,D,E,F}, A = MSB.
REQ-008 SHALL have port busy, output, 1: high in RUN and CMP.
REQ-009 SHALL have port done, output, 1: high in DONE only.
REQ-010 SHALL have port pass, output, 1: signature == GOLDEN_SIG, valid while done=1.
REQ-011 SHALL have port signature, output, 8: current SISR contents.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, CMP, DONE.
REQ-013 IDLE: start=1 -> RUN; load pat with first pattern, clear cnt and signature; start=0 -> remain.
REQ-014 RUN: each edge, shift cut_z into SISR, increment cnt, load next pattern into pat; on the edge where cnt==NUM_PAT-1 -> CMP, pat <= 0.
REQ-015 SISR update SHALL be: sig <= {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0,cut_z} (polynomial x^8+x^4+x^3+x^2+1).
REQ-016 cut_z SHALL be sampled in the same cycle as the pat value producing it (CUT combinational, zero-cycle path).
REQ-017 CMP: one cycle; pass <= (sig==GOLDEN_SIG); -> DONE.
REQ-018 DONE: done=1, pass and signature held; start=1 -> RUN (restart, same as IDLE); start=0 -> remain.
REQ-019 Latency: done SHALL rise on the (NUM_PAT+1)th rising edge after the edge that sampled start.
REQ-020 start SHALL be ignored in RUN and CMP; no abort, no restart.
REQ-021 cnt SHALL be 7 bits; pattern sequence SHALL never wrap within a run.
REQ-022 pat SHALL be 0 in IDLE, CMP and DONE.

Reset
REQ-023 rst=1 at any edge, including mid-RUN, SHALL force IDLE, pat=0, cnt=0, signature=0, busy=0, done=0, pass=0.
REQ-024 rst SHALL take priority over start on the same edge.
REQ-025 A run aborted by rst SHALL NOT resume; a new start is required.

Configuration
REQ-026 Macro TEST_SEQ_LFSR_EN SHALL select pattern source.
REQ-027 Without TEST_SEQ_LFSR_EN: pattern k = k[5:0] (binary count 0,1,2,...,NUM_PAT-1).
REQ-028 With TEST_SEQ_LFSR_EN: 6-bit Fibonacci LFSR, x^6+x^5+1, seed 6'b000001, next = {p[4:0], p[5]^p[4]}; pattern 63 (index 63) SHALL be 6'b000000 so NUM_PAT=64 covers all 64 inputs.
REQ-029 Both modes SHALL have identical FSM timing and SISR behaviour.

Verification
REQ-030 Counter mode, cut_z tied 0, GOLDEN_SIG=8'h00, start 1 cycle -> pat steps 0..63, done rises 65 edges after start, signature=8'h00, pass=1.
REQ-031 Counter mode, cut_z tied 1 for only the first pattern (pat==0), NUM_PAT=2 -> signature=8'h02, pass=0 with GOLDEN_SIG=8'h00.
REQ-032 rst asserted at RUN cycle 10 -> next edge IDLE, all outputs 0; start afterwards -> full 64-pattern run from pattern 0.
REQ-033 start held high throughout -> single run completes, DONE then immediately restarts RUN with signature cleared.
REQ-034 TEST_SEQ_LFSR_EN defined -> 64 patterns observed, all distinct, first 6'b000001, last 6'b000000.
REQ-035 start pulsed during RUN cycle 20 -> no effect; done timing unchanged.

Source files
------------

// File: rtl/test_seq_ctrl.sv
// rtl/test_seq_ctrl.sv - BIST pattern sequencer with 8-bit SISR signature compaction
// Define TEST_SEQ_LFSR_EN to source patterns from a 6-bit LFSR instead of a binary count.
module test_seq_ctrl #(
    parameter logic [7:0] GOLDEN_SIG = 8'h00,
    parameter int         NUM_PAT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cut_z,
    output logic [5:0] pat,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    localparam logic [6:0] LAST_CNT = 7'(NUM_PAT - 1);
`ifdef TEST_SEQ_LFSR_EN
    localparam logic [5:0] FIRST_PAT = 6'd1;
`else
    localparam logic [5:0] FIRST_PAT = 6'd0;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [6:0] cnt;
    logic [5:0] pat_nxt;
    logic [7:0] sig_nxt;
    logic       last_cnt;

    assign last_cnt = (cnt == LAST_CNT);

`ifdef TEST_SEQ_LFSR_EN
    // The LFSR never reaches zero, so index 63 is forced to all-zero to cover every input.
    always_comb begin
        pat_nxt = {pat[4:0], pat[5] ^ pat[4]};
        if (cnt == 7'd62) begin
            pat_nxt = 6'd0;
        end
    end
`else
    always_comb begin
        pat_nxt = cnt[5:0] + 6'd1;
    end
`endif

    assign sig_nxt = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00) ^ {7'b0, cut_z};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_cnt) state_nxt = CMP;
            CMP:     state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == CMP);
        done = (state == DONE);
    end

    // cut_z is the combinational response to the pat value held this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat       <= 6'd0;
            cnt       <= 7'd0;
            signature <= 8'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pat       <= FIRST_PAT;
                        cnt       <= 7'd0;
                        signature <= 8'd0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    signature <= sig_nxt;
                    cnt       <= cnt + 7'd1;
                    pat       <= last_cnt ? 6'd0 : pat_nxt;
                end
                CMP: begin
                    pass <= (signature == GOLDEN_SIG);
                end
                default: begin
                    pat <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_seq_ctrl.sv
// tb/tb_test_seq_ctrl.sv - scoreboard bench for test_seq_ctrl (64-pattern and 2-pattern instances)
module tb_test_seq_ctrl;

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       cut_z_a, cut_z_b;
    logic [5:0] pat_a, pat_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] sig_a, sig_b;

    int         n_chk = 0;
    int         n_fail = 0;
    int         edge_cnt = 0;
    int         z_mode = 0;
    logic [5:0] exp_pat [64];
    exp_t       q_a[$];
    exp_t       q_b[$];
    exp_t       e;
    logic       done_a_q = 1'b0;
    logic       done_b_q = 1'b0;
`ifdef TEST_SEQ_LFSR_EN
    localparam logic [5:0] FIRST = 6'd1;
`else
    localparam logic [5:0] FIRST = 6'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Bench-side CUT models.
    assign cut_z_a = (z_mode == 1) || (z_mode == 2 && (pat_a[0] ^ pat_a[5])) ||
                     (z_mode == 3 && pat_a == exp_pat[63]);
    assign cut_z_b = (pat_b == FIRST);

    test_seq_ctrl #(.GOLDEN_SIG(8'h00), .NUM_PAT(64)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cut_z(cut_z_a), .pat(pat_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

    test_seq_ctrl #(.GOLDEN_SIG(8'h00), .NUM_PAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cut_z(cut_z_b), .pat(pat_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_sig(input int zm);
        logic [7:0] s = 8'h00;
        logic       z;
        for (int k = 0; k < 64; k++) begin
            z = (zm == 1) || (zm == 2 && (exp_pat[k][0] ^ exp_pat[k][5])) || (zm == 3 && k == 63);
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, z};
        end
        return s;
    endfunction

    // Monitor: compares each rising done against the oldest queued expectation.
    always @(negedge clk) begin
        if (done_a && !done_a_q) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("a_signature", sig_a, e.sig);
                chk("a_pass", pass_a, e.pass);
                chk("a_done_edge", edge_cnt, e.due);
            end
        end
        if (done_b && !done_b_q) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                e = q_b.pop_front();
                chk("b_signature", sig_b, e.sig);
                chk("b_pass", pass_b, e.pass);
                chk("b_done_edge", edge_cnt, e.due);
            end
        end
        done_a_q = done_a;
        done_b_q = done_b;
    end

    task automatic drain();
        for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pat"}, pat_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_pass"}, pass_a, 0);
        chk({tag, "_signature"}, sig_a, 0);
    endtask

    task automatic run(input int zm, input bit pulse20, input bit abort10);
        logic [7:0]  es;
        logic [63:0] seen = '0;
        int          s;
        z_mode = zm;
        es = model_sig(zm);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        s = edge_cnt;
        start_a = 1'b0;
        if (!abort10) q_a.push_back('{es, (es == 8'h00), s + 65});
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("pat_step", pat_a, exp_pat[k]);
            chk("busy_run", busy_a, 1);
            seen[pat_a] = 1'b1;
            if (pulse20 && k == 20) start_a = 1'b1;
            if (pulse20 && k == 21) start_a = 1'b0;
            if (abort10 && k == 10) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_zero("abort");
                repeat (3) @(negedge clk);
                chk("abort_no_resume", busy_a, 0);
                return;
            end
        end
        chk("distinct_patterns", $countones(seen), 64);
        @(negedge clk);
        chk("cmp_pat_zero", pat_a, 0);
        chk("cmp_busy", busy_a, 1);
        drain();
    endtask

    initial begin
        int s;
        int i;
`ifdef TEST_SEQ_LFSR_EN
        begin
            logic [5:0] p = 6'd1;
            for (int k = 0; k < 63; k++) begin
                exp_pat[k] = p;
                p = {p[4:0], p[5] ^ p[4]};
            end
            exp_pat[63] = 6'd0;
        end
`else
        for (int k = 0; k < 64; k++) exp_pat[k] = 6'(k);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        chk("reset_b_busy", busy_b, 0);

        // Reset wins over a simultaneous start.
        start_a = 1'b1;
        @(negedge clk);
        chk("rst_priority_busy", busy_a, 0);
        rst = 1'b0;
        start_a = 1'b0;

        run(0, 0, 0);
        run(1, 0, 0);
        run(2, 1, 0);
        run(3, 0, 1);
        run(3, 0, 0);

        // Two-pattern instance: Z high only on the first pattern gives 8'h02.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk); #1;
        s = edge_cnt;
        start_b = 1'b0;
        q_b.push_back('{8'h02, 1'b0, s + 3});
        drain();

        // start held high: completes, then restarts straight from DONE with a cleared SISR.
        z_mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        s = edge_cnt;
        q_a.push_back('{model_sig(1), (model_sig(1) == 8'h00), s + 65});
        q_a.push_back('{model_sig(1), (model_sig(1) == 8'h00), s + 131});
        i = 0;
        while (edge_cnt < s + 66 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("restart_edge_reached", edge_cnt, s + 66);
        chk("restart_signature", sig_a, 0);
        chk("restart_busy", busy_a, 1);
        chk("restart_done", done_a, 0);
        chk("restart_pat", pat_a, exp_pat[0]);
        start_a = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        chk("stays_done", done_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
